rr_resource_arbiter: RTL

//   Round-robin arbiter/sequencer that shares one burst-oriented resource among
//   NUM_REQ requesters. Grants one requester at a time and holds the grant for a

---
 rtl/rr_resource_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter that lends one burst-oriented resource to NUM_REQ clients.
// Grant appears one cycle after request; res_ready_i low stalls the burst in place.
module rr_resource_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LEN_W-1:0] len_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [ID_W-1:0]          gnt_id_o,
  output logic                     busy_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [LEN_W-1:0]         beat_cnt_o,
  output logic [NUM_REQ-1:0]       done_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic [ID_W-1:0]    pick_id;
  logic               pick_found;
  logic [LEN_W-1:0]   pick_len;

  // Scan starts just after the last winner, so that winner is lowest priority.
  always_comb begin
    pick_id    = '0;
    pick_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && req_i[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
    pick_len = len_i[int'(pick_id)*LEN_W +: LEN_W];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = BUSY;
          gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
          gnt_id_d = pick_id;
          len_d    = (pick_len == '0) ? LEN_W'(1) : pick_len;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        if (res_ready_i) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d  = IDLE;
            done_d   = gnt_q;
            gnt_d    = '0;
            gnt_id_d = '0;
            cnt_d    = '0;
            ptr_d    = gnt_id_q;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= ID_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      gnt_id_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign busy_o      = (state_q == BUSY);
  assign res_valid_o = (state_q == BUSY);
  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign beat_cnt_o  = cnt_q;
  assign done_o      = done_q;

endmodule
